vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA sync pulse generator. It takes active-low horizontal and vertical sync pulses from an external source, such as a camera or a second video pipe, and recovers pixel coordinates and an active-video flag. It also measures line period and pulse width, and declares lock once line timing is stable. It sits at the input of the capture path, ahead of the frame buffer that feeds the classifier.

---
 rtl/vga_rx_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 33 +++
 rtl/vga_sync_decoder.sv | 158 +++++++++++++++
 tb/tb_vga_sync_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared types and default 640x480 receive timing for the VGA sync decoder.
// No logic, no latency, no flow control.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } vga_rx_state_t;

    localparam int VGA_CNT_W      = 13;
    localparam int VGA_POS_W      = 11;
    localparam int VGA_H_START    = 144;
    localparam int VGA_H_ACT      = 640;
    localparam int VGA_V_START    = 35;
    localparam int VGA_V_ACT      = 480;
    localparam int VGA_LOCK_LINES = 4;
    localparam int VGA_TOL        = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an async sync input plus edge detector.
// level is 2 clocks behind the pin; fall/rise are high the cycle level changes.
// No flow control; idles high so reset release never produces a false edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign fall  = prev & ~s2;
    assign rise  = ~prev & s2;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, active flag, line timing and lock from external syncs; VGA_RX_MEAS_EN exports h_period/h_pulse.
// line_start/frame_start 3 clocks after the pin falls; pix/active combinational from the counters.
// No flow control: the decoder follows the source and flags timing loss via err.
module vga_sync_decoder
    import vga_rx_pkg::*;
#(
    parameter int CNT_W      = VGA_CNT_W,
    parameter int POS_W      = VGA_POS_W,
    parameter int H_START    = VGA_H_START,
    parameter int H_ACT      = VGA_H_ACT,
    parameter int V_START    = VGA_V_START,
    parameter int V_ACT      = VGA_V_ACT,
    parameter int LOCK_LINES = VGA_LOCK_LINES,
    parameter int TOL        = VGA_TOL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [POS_W-1:0] pix_x,
    output logic [POS_W-1:0] pix_y,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_period,
    output logic [CNT_W-1:0] h_pulse,
    output logic             locked,
    output logic             err
);

    localparam int MW = $clog2(LOCK_LINES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_START + H_ACT);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_START + V_ACT);
    localparam logic [CNT_W:0]   TOL_X = (CNT_W+1)'(TOL);

    logic h_level, h_fall, h_rise;
    logic v_level, v_fall, v_rise;

    sync_edge_det u_hsync (.clk(clk), .rst_n(rst_n), .din(hsync_in),
                           .level(h_level), .fall(h_fall), .rise(h_rise));
    sync_edge_det u_vsync (.clk(clk), .rst_n(rst_n), .din(vsync_in),
                           .level(v_level), .fall(v_fall), .rise(v_rise));

    logic [CNT_W-1:0] h_cnt, v_cnt, h_meas, ref_period;
    logic [CNT_W:0]   meas_x, ref_x;
    logic [MW-1:0]    match_cnt;
    logic             timeout, period_ok, h_win, v_win;
    vga_rx_state_t    state;

    // h_meas is the period/width of whatever just ended, counting the current clock
    assign h_meas    = h_cnt + CNT_W'(1);
    assign timeout   = (h_cnt == CNT_MAX);
    assign meas_x    = {1'b0, h_meas};
    assign ref_x     = {1'b0, ref_period};
    assign period_ok = (meas_x <= ref_x + TOL_X) && (ref_x <= meas_x + TOL_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_fall;
            frame_start <= v_fall;
            if (h_fall)
                h_cnt <= '0;
            else if (!timeout)
                h_cnt <= h_meas;
            if (v_fall)
                v_cnt <= '0;
            else if (h_fall && v_cnt != CNT_MAX)
                v_cnt <= v_cnt + CNT_W'(1);
        end
    end

    // A new reference period always counts as the first line of its own run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            match_cnt  <= '0;
            ref_period <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if (timeout && state != SEARCH) begin
                state     <= SEARCH;
                match_cnt <= '0;
                err       <= (state == LOCKED);
            end else if (h_fall) begin
                case (state)
                    SEARCH: begin
                        state     <= TRACK;
                        match_cnt <= '0;
                    end
                    TRACK: begin
                        if (match_cnt != '0 && period_ok) begin
                            match_cnt <= match_cnt + MW'(1);
                            if (match_cnt == MW'(LOCK_LINES - 1))
                                state <= LOCKED;
                        end else begin
                            ref_period <= h_meas;
                            match_cnt  <= MW'(1);
                        end
                    end
                    LOCKED: begin
                        if (!period_ok) begin
                            err        <= 1'b1;
                            state      <= TRACK;
                            ref_period <= h_meas;
                            match_cnt  <= MW'(1);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);
    assign h_win  = (h_cnt >= H_LO) && (h_cnt < H_HI);
    assign v_win  = (v_cnt >= V_LO) && (v_cnt < V_HI);
    assign active = h_win && v_win && locked;
    assign pix_x  = h_win ? POS_W'(h_cnt - H_LO) : '0;
    assign pix_y  = v_win ? POS_W'(v_cnt - V_LO) : '0;

`ifdef VGA_RX_MEAS_EN
    logic [CNT_W-1:0] h_period_q, h_pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_period_q <= '0;
            h_pulse_q  <= '0;
        end else begin
            if (h_fall && !timeout)
                h_period_q <= h_meas;
            if (h_rise)
                h_pulse_q <= h_meas;
        end
    end

    assign h_period = h_period_q;
    assign h_pulse  = h_pulse_q;

    logic unused_sync;
    assign unused_sync = ^{h_level, v_level, v_rise};
`else
    assign h_period = '0;
    assign h_pulse  = '0;

    logic unused_sync;
    assign unused_sync = ^{h_level, v_level, v_rise, h_rise};
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: small-timing source with random jitter/glitches vs. an event-level model.
module tb_vga_sync_decoder;

    localparam int CNT_W = 13;
    localparam int POS_W = 11;
    localparam int HS    = 20;
    localparam int HA    = 64;
    localparam int VS    = 4;
    localparam int VA    = 20;
    localparam int LOCKN = 4;
    localparam int TOL   = 2;
    localparam int PER   = 100;
    localparam int HLOW  = 12;
    localparam int LINES = 30;
    localparam int VLOW  = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef VGA_RX_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic hsync_in = 1'b1;
    logic vsync_in = 1'b1;
    logic [POS_W-1:0] pix_x, pix_y;
    logic active, line_start, frame_start, locked, err;
    logic [CNT_W-1:0] h_period, h_pulse;

    vga_sync_decoder #(
        .CNT_W(CNT_W), .POS_W(POS_W), .H_START(HS), .H_ACT(HA),
        .V_START(VS), .V_ACT(VA), .LOCK_LINES(LOCKN), .TOL(TOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pix_x(pix_x), .pix_y(pix_y), .active(active),
        .line_start(line_start), .frame_start(frame_start),
        .h_period(h_period), .h_pulse(h_pulse), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit hsamp [0:65535];
    bit vsamp [0:65535];
    int n = 0;
    int rst_last = 0;

    // model: counters as elapsed clocks, lock as length of the current run of agreeing periods
    int m_hc, m_vc, m_hper, m_hpul, m_ref, m_run;
    bit m_search, m_ls, m_fs, m_err;

    int err_seen = 0;
    int act_cnt = 0;
    int last_act = -1;
    bit first_pend = 0;
    int first_px = -1;
    int first_py = -1;
    bit watch = 0;
    int lsn = 0;
    bit rst_req = 0;
    int rst_hold = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit hs_at(input int k);
        if (k < 0 || k <= rst_last) return 1'b1;
        return hsamp[k];
    endfunction

    function automatic bit vs_at(input int k);
        if (k < 0 || k <= rst_last) return 1'b1;
        return vsamp[k];
    endfunction

    function automatic bit m_locked();
        return !m_search && m_run >= LOCKN;
    endfunction

    function automatic bit m_hwin();
        return m_hc >= HS && m_hc < HS + HA;
    endfunction

    function automatic bit m_vwin();
        return m_vc >= VS && m_vc < VS + VA;
    endfunction

    task automatic model_reset();
        m_hc = 0; m_vc = 0; m_hper = 0; m_hpul = 0; m_ref = 0; m_run = 0;
        m_search = 1; m_ls = 0; m_fs = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int prev;
        int per;
        bit rise;
        prev = m_hc;
        m_ls = (hs_at(n-2) == 1'b0) && (hs_at(n-3) == 1'b1);
        m_fs = (vs_at(n-2) == 1'b0) && (vs_at(n-3) == 1'b1);
        rise = (hs_at(n-2) == 1'b1) && (hs_at(n-3) == 1'b0);
        m_err = 0;
        if (m_ls) m_hc = 0;
        else if (m_hc < CMAX) m_hc++;
        if (m_fs) m_vc = 0;
        else if (m_ls && m_vc < CMAX) m_vc++;
        if (m_ls && prev != CMAX) m_hper = prev + 1;
        if (rise) m_hpul = (prev + 1) & CMAX;
        if (prev == CMAX && !m_search) begin
            m_err = (m_run >= LOCKN);
            m_search = 1;
            m_run = 0;
        end else if (m_ls) begin
            if (m_search) begin
                m_search = 0;
                m_run = 0;
            end else begin
                per = prev + 1;
                if (m_run > 0 && per >= m_ref - TOL && per <= m_ref + TOL) begin
                    m_run++;
                end else begin
                    m_err = (m_run >= LOCKN);
                    m_ref = per;
                    m_run = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("pix_x", pix_x, m_hwin() ? m_hc - HS : 0);
        chk("pix_y", pix_y, m_vwin() ? m_vc - VS : 0);
        chk("active", active, m_hwin() && m_vwin() && m_locked());
        chk("line_start", line_start, m_ls);
        chk("frame_start", frame_start, m_fs);
        chk("h_period", h_period, MEAS ? m_hper : 0);
        chk("h_pulse", h_pulse, MEAS ? m_hpul : 0);
        chk("locked", locked, m_locked());
        chk("err", err, m_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_x"}, pix_x, 0);
        chk({tag, "_pix_y"}, pix_y, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_line_start"}, line_start, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_h_period"}, h_period, 0);
        chk({tag, "_h_pulse"}, h_pulse, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic step(input bit h, input bit v);
        if (n >= 65530) begin
            $display("FAIL step_budget got=%0d exp<65530", n);
            $fatal(1, "cycle budget exhausted");
        end
        hsync_in = h;
        vsync_in = v;
        hsamp[n+1] = h;
        vsamp[n+1] = v;
        @(posedge clk);
        #1;
        n++;
        if (!rst_n) begin
            rst_last = n;
            model_reset();
        end else begin
            model_edge();
        end
        compare_all();
        if (err) err_seen++;
        if (m_fs) begin
            chk("fs_with_ls", line_start, 1);
            last_act = act_cnt;
            act_cnt = 0;
            first_pend = 1;
        end
        if (active) act_cnt++;
        if (first_pend && active) begin
            first_px = pix_x;
            first_py = pix_y;
            first_pend = 0;
        end
        if (watch && m_ls) begin
            lsn++;
            if (lsn == LOCKN) chk("prelock", locked, 0);
            if (lsn == LOCKN + 1) begin
                chk("lock_5th", locked, 1);
                watch = 0;
            end
        end
        if (rst_req && m_hc == HS + 30 && m_vwin() && m_locked()) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero("midrst");
            rst_req = 0;
            rst_hold = 3;
        end else if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) begin
                rst_n = 1'b1;
                watch = 1;
                lsn = 0;
            end
        end
    endtask

    task automatic line(input int per, input bit vlow, input int glitch);
        for (int i = 0; i < per; i++)
            step((i < HLOW || i == glitch) ? 1'b0 : 1'b1, vlow ? 1'b0 : 1'b1);
    endtask

    task automatic frame(input int jit, input int long_line, input int glitch_line);
        int per;
        int g;
        for (int l = 0; l < LINES; l++) begin
            per = PER;
            if (jit > 0) per = PER + int'($urandom_range(0, 2 * jit)) - jit;
            if (l == long_line) per = PER + 5;
            g = (l == glitch_line) ? int'($urandom_range(30, 70)) : -1;
            line(per, l < VLOW, g);
        end
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        rst_n = 1'b1;
        watch = 1;
        lsn = 0;
        for (int i = 0; i < 37; i++) step(1'b1, 1'b1);

        // clean frames: lock, full-frame active count, first pixel, measurements
        for (int f = 0; f < 3; f++) frame(0, -1, -1);
        chk("active_per_frame", last_act, HA * VA);
        chk("first_px", first_px, 0);
        chk("first_py", first_py, 0);
        chk("period_const", h_period, MEAS ? PER : 0);
        chk("pulse_const", h_pulse, MEAS ? HLOW : 0);

        err_seen = 0;
        frame(TOL, -1, -1);
        chk("jitter_err", err_seen, 0);
        chk("jitter_locked", locked, 1);

        err_seen = 0;
        frame(0, 10, -1);
        chk("long_line_err", err_seen, 1);
        chk("long_line_relock", locked, 1);

        err_seen = 0;
        for (int i = 0; i < 8300; i++) step(1'b1, 1'b1);
        chk("timeout_err", err_seen, 1);
        chk("timeout_locked", locked, 0);
        chk("timeout_active", active, 0);
        watch = 1;
        lsn = 0;
        frame(0, -1, -1);
        frame(0, -1, -1);
        chk("timeout_relock", locked, 1);

        rst_req = 1;
        frame(0, -1, -1);
        frame(0, -1, -1);
        chk("reset_relock", locked, 1);

        err_seen = 0;
        frame(0, -1, 12);
        chk("glitch_err", err_seen, 1);
        chk("glitch_relock", locked, 1);

        frame(TOL, -1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
